// File: rtl/oclib_pkg.sv
// oclib_pkg: shared CSR request/feedback structs, broadcast IDs and local-adapter FSM states.
//   csr_32_noc_s    : request  {toblock, space, address, wdata, read, write}
//   csr_32_noc_fb_s : feedback {rdata, ready, error}
package oclib_pkg;

    typedef struct packed {
        logic [31:0] toblock;
        logic [3:0]  space;
        logic [31:0] address;
        logic [31:0] wdata;
        logic        read;
        logic        write;
    } csr_32_noc_s;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
        logic        error;
    } csr_32_noc_fb_s;

    // An instance parameterised with these IDs answers to every block / space.
    localparam logic [31:0] BcBlockIdAny = 32'hFFFF_FFFF;
    localparam logic [3:0]  BcSpaceIdAny = 4'hF;

    typedef logic [1:0] csr_adapter_state_t;
    localparam csr_adapter_state_t CsrAdapterIdle    = 2'd0;
    localparam csr_adapter_state_t CsrAdapterAccess  = 2'd1;
    localparam csr_adapter_state_t CsrAdapterRespond = 2'd2;
    localparam csr_adapter_state_t CsrAdapterRelease = 2'd3;

endpackage

// File: rtl/oclib_csr_check_selected.sv
// oclib_csr_check_selected: decides whether a CSR request addresses this block.
//   csrSelect : in  qualifier for the request
//   csr       : in  request struct (only toblock and space are inspected)
//   match     : out combinational hit
module oclib_csr_check_selected
    import oclib_pkg::*;
#(
    parameter type         CsrType       = csr_32_noc_s,
    parameter logic [31:0] AnswerToBlock = BcBlockIdAny,
    parameter logic [3:0]  AnswerToSpace = BcSpaceIdAny
) (
    input  logic   csrSelect,
    input  CsrType csr,
    output logic   match
);

    logic block_hit;
    logic space_hit;
    logic csr_unused;

    assign block_hit  = (AnswerToBlock == BcBlockIdAny) || (csr.toblock == AnswerToBlock);
    assign space_hit  = (AnswerToSpace == BcSpaceIdAny) || (csr.space == AnswerToSpace);
    assign match      = csrSelect && block_hit && space_hit;
    assign csr_unused = ^{csr.address, csr.wdata, csr.read, csr.write};

endmodule

// File: rtl/oclib_csr_local_adapter.sv
// oclib_csr_local_adapter: terminates a CSR request on a block's local register port.
//   clock, reset (async, active-high)
//   csrSelect, csr -> csrFb       : CSR tree request / OR-combinable feedback
//   localRead, localWrite, localAddress, localWdata : held local access
//   localRdata, localReady, localError               : local completion
// Optional: define OC_LIBRARY_CSR_ADAPTER_TIMEOUT_EN to abort a local access
// after TimeoutCycles cycles with an error response.
module oclib_csr_local_adapter
    import oclib_pkg::*;
#(
    parameter type         CsrType       = csr_32_noc_s,
    parameter type         CsrFbType     = csr_32_noc_fb_s,
    parameter logic [31:0] AnswerToBlock = BcBlockIdAny,
    parameter logic [3:0]  AnswerToSpace = BcSpaceIdAny,
    parameter int          TimeoutCycles = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        csrSelect,
    input  CsrType      csr,
    output CsrFbType    csrFb,
    output logic        localRead,
    output logic        localWrite,
    output logic [31:0] localAddress,
    output logic [31:0] localWdata,
    input  logic [31:0] localRdata,
    input  logic        localReady,
    input  logic        localError
);

    logic               match;
    logic               expired;
    csr_adapter_state_t state_q, state_d;
    logic               rd_q, rd_d, wr_q, wr_d;
    logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic               err_q, err_d;

    oclib_csr_check_selected #(
        .CsrType       (CsrType),
        .AnswerToBlock (AnswerToBlock),
        .AnswerToSpace (AnswerToSpace)
    ) u_check (
        .csrSelect (csrSelect),
        .csr       (csr),
        .match     (match)
    );

`ifdef OC_LIBRARY_CSR_ADAPTER_TIMEOUT_EN
    logic [15:0] count_q;

    // Zero outside Access, so it is already clear on entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= (state_q == CsrAdapterAccess) ? count_q + 16'd1 : '0;
    end

    assign expired = (state_q == CsrAdapterAccess) && (count_q == 16'(TimeoutCycles - 1));
`else
    logic timeout_unused;

    assign timeout_unused = TimeoutCycles[0];
    assign expired        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            CsrAdapterIdle: begin
                if (match && (csr.read ^ csr.write)) begin
                    state_d = CsrAdapterAccess;
                    rd_d    = csr.read;
                    wr_d    = csr.write;
                    addr_d  = csr.address;
                    wdata_d = csr.wdata;
                end else if (match && csr.read && csr.write) begin
                    state_d = CsrAdapterRespond;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            CsrAdapterAccess: begin
                // localReady wins over a timeout expiring in the same cycle.
                if (localReady || expired) begin
                    state_d = CsrAdapterRespond;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rdata_d = (localReady && rd_q) ? localRdata : '0;
                    err_d   = localReady ? localError : 1'b1;
                end
            end
            CsrAdapterRespond: state_d = CsrAdapterRelease;
            default:           state_d = (csr.read || csr.write) ? CsrAdapterRelease : CsrAdapterIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= CsrAdapterIdle;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Feedback stays all-zero outside Respond so many blocks can be OR-combined.
    always_comb begin
        csrFb       = '0;
        csrFb.ready = (state_q == CsrAdapterRespond);
        csrFb.rdata = (state_q == CsrAdapterRespond) ? rdata_q : '0;
        csrFb.error = (state_q == CsrAdapterRespond) && err_q;
    end

    assign localRead    = rd_q;
    assign localWrite   = wr_q;
    assign localAddress = addr_q;
    assign localWdata   = wdata_q;

endmodule

// File: tb/tb_oclib_csr_local_adapter.sv
// tb_oclib_csr_local_adapter: table-driven, random and corner-case checks of the CSR local adapter.
module tb_oclib_csr_local_adapter;
    import oclib_pkg::*;

    logic           clock, reset, csrSelect;
    csr_32_noc_s    csr;
    csr_32_noc_fb_s csrFb;
    logic           localRead, localWrite, localReady, localError;
    logic [31:0]    localAddress, localWdata, localRdata;

    int checks = 0;
    int errors = 0;

    oclib_csr_local_adapter #(
        .AnswerToBlock (32'h12),
        .AnswerToSpace (4'h1),
        .TimeoutCycles (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .csrSelect    (csrSelect),
        .csr          (csr),
        .csrFb        (csrFb),
        .localRead    (localRead),
        .localWrite   (localWrite),
        .localAddress (localAddress),
        .localWdata   (localWdata),
        .localRdata   (localRdata),
        .localReady   (localReady),
        .localError   (localError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] blk;
        logic [3:0]  sp;
        logic        sel, rd, wr;
        logic [31:0] addr, wdata, rdata;
        logic        lerr;
        int          dly;
        int          exp_strobes;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Transaction-level expectation: who answers, how long the strobe lasts and what comes back.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic hit = v.sel && v.blk == 32'h12 && v.sp == 4'h1;
        r.exp_strobes = 0;
        r.exp_lat     = -1;
        r.exp_rdata   = '0;
        r.exp_err     = 1'b0;
        if (hit && v.rd && v.wr) begin
            r.exp_lat = 1;
            r.exp_err = 1'b1;
        end else if (hit && (v.rd || v.wr)) begin
            r.exp_strobes = v.dly + 1;
            r.exp_lat     = v.dly + 2;
            r.exp_rdata   = v.rd ? v.rdata : 32'h0;
            r.exp_err     = v.lerr;
        end
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        int          strobes = 0;
        int          lat = -1;
        int          readies = 0;
        logic [31:0] rd_got = '0;
        logic        err_got = 1'b0;
        logic        bad_fb = 1'b0;
        logic        bad_strobe = 1'b0;
        @(negedge clock);
        csrSelect = v.sel;
        csr = '{toblock: v.blk, space: v.sp, address: v.addr, wdata: v.wdata, read: v.rd, write: v.wr};
        localRdata = $urandom;
        localReady = 1'b0;
        localError = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock);
            #1;
            if (csrFb.ready) begin
                readies++;
                if (lat < 0) begin
                    lat     = c;
                    rd_got  = csrFb.rdata;
                    err_got = csrFb.error;
                end
                csr.read  = 1'b0;
                csr.write = 1'b0;
            end else if (csrFb != '0) bad_fb = 1'b1;
            if (localRead || localWrite) begin
                strobes++;
                if (localRead != v.rd || localWrite != v.wr || localAddress != v.addr || localWdata != v.wdata)
                    bad_strobe = 1'b1;
                if (strobes == v.dly + 1) begin
                    localReady = 1'b1;
                    localRdata = v.rdata;
                    localError = v.lerr;
                end
            end else begin
                localReady = 1'b0;
                localRdata = $urandom;
                localError = 1'b0;
            end
        end
        csr.read  = 1'b0;
        csr.write = 1'b0;
        chk({nm, " strobes"}, strobes, v.exp_strobes);
        chk({nm, " latency"}, lat, v.exp_lat);
        chk({nm, " ready count"}, readies, (v.exp_lat >= 0) ? 1 : 0);
        chk({nm, " rdata"}, rd_got, v.exp_rdata);
        chk({nm, " error"}, err_got, v.exp_err);
        chk({nm, " strobe fields"}, bad_strobe, 0);
        chk({nm, " idle fb zero"}, bad_fb, 0);
    endtask

    vec_t tbl[8];

    initial begin
        int          strobes, readies, lat;
        logic        err_got;
        logic [31:0] rd_got;
        vec_t        v;

        tbl[0] = '{blk: 32'h12, sp: 4'h1, sel: 1, rd: 1, wr: 0, addr: 32'h40, wdata: 32'h0, rdata: 32'hDEADBEEF,
                   lerr: 0, dly: 2, exp_strobes: 3, exp_lat: 4, exp_rdata: 32'hDEADBEEF, exp_err: 0};
        tbl[1] = '{blk: 32'h13, sp: 4'h1, sel: 1, rd: 0, wr: 1, addr: 32'h44, wdata: 32'hA5A5A5A5, rdata: 32'h0,
                   lerr: 0, dly: 0, exp_strobes: 0, exp_lat: -1, exp_rdata: 32'h0, exp_err: 0};
        tbl[2] = '{blk: 32'h12, sp: 4'h1, sel: 1, rd: 0, wr: 1, addr: 32'h44, wdata: 32'hA5A5A5A5, rdata: 32'h11111111,
                   lerr: 0, dly: 0, exp_strobes: 1, exp_lat: 2, exp_rdata: 32'h0, exp_err: 0};
        tbl[3] = '{blk: 32'h12, sp: 4'h1, sel: 1, rd: 1, wr: 1, addr: 32'h48, wdata: 32'h5, rdata: 32'h77,
                   lerr: 0, dly: 0, exp_strobes: 0, exp_lat: 1, exp_rdata: 32'h0, exp_err: 1};
        tbl[4] = '{blk: 32'h12, sp: 4'h1, sel: 1, rd: 0, wr: 1, addr: 32'h4C, wdata: 32'hCAFE0001, rdata: 32'h99,
                   lerr: 1, dly: 1, exp_strobes: 2, exp_lat: 3, exp_rdata: 32'h0, exp_err: 1};
        tbl[5] = '{blk: 32'h12, sp: 4'h1, sel: 0, rd: 1, wr: 0, addr: 32'h50, wdata: 32'h0, rdata: 32'h1,
                   lerr: 0, dly: 0, exp_strobes: 0, exp_lat: -1, exp_rdata: 32'h0, exp_err: 0};
        tbl[6] = '{blk: 32'h12, sp: 4'h2, sel: 1, rd: 1, wr: 0, addr: 32'h54, wdata: 32'h0, rdata: 32'h2,
                   lerr: 0, dly: 0, exp_strobes: 0, exp_lat: -1, exp_rdata: 32'h0, exp_err: 0};
        tbl[7] = '{blk: 32'h12, sp: 4'h1, sel: 1, rd: 1, wr: 0, addr: 32'h58, wdata: 32'h0, rdata: 32'h12345678,
                   lerr: 1, dly: 0, exp_strobes: 1, exp_lat: 2, exp_rdata: 32'h12345678, exp_err: 1};

        reset = 1'b1;
        csrSelect = 1'b0;
        csr = '0;
        localRdata = '0;
        localReady = 1'b0;
        localError = 1'b0;
        #1;
        chk("reset fb", csrFb, 0);
        chk("reset strobes", {localRead, localWrite}, 0);
        chk("reset addr/wdata", {localAddress, localWdata}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            v.blk   = ($urandom_range(0, 3) == 0) ? 32'h13 : 32'h12;
            v.sp    = ($urandom_range(0, 5) == 0) ? 4'h2 : 4'h1;
            v.sel   = ($urandom_range(0, 7) != 0);
            v.rd    = 1'($urandom);
            v.wr    = 1'($urandom);
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.lerr  = ($urandom_range(0, 3) == 0);
            v.dly   = $urandom_range(0, 5);
            run_vec(model(v), $sformatf("rand%0d", i));
        end

        // Collision held for 10 cycles must be answered exactly once.
        @(negedge clock);
        csrSelect = 1'b1;
        csr = '{toblock: 32'h12, space: 4'h1, address: 32'h60, wdata: 32'h0, read: 1'b1, write: 1'b1};
        readies = 0;
        strobes = 0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock);
            #1;
            if (csrFb.ready) begin
                readies++;
                if (lat < 0) lat = c;
            end
            if (localRead || localWrite) strobes++;
        end
        chk("held collision ready count", readies, 1);
        chk("held collision latency", lat, 1);
        chk("held collision strobes", strobes, 0);
        @(negedge clock);
        csr.read = 1'b0;
        csr.write = 1'b0;
        repeat (2) @(negedge clock);

        // Local side never answers.
        csr = '{toblock: 32'h12, space: 4'h1, address: 32'h80, wdata: 32'h0, read: 1'b1, write: 1'b0};
        strobes = 0;
        lat = -1;
        err_got = 1'b0;
        rd_got = '0;
        for (int c = 1; c <= 130; c++) begin
            @(posedge clock);
            #1;
            if (localRead) strobes++;
            if (csrFb.ready && lat < 0) begin
                lat = c;
                err_got = csrFb.error;
                rd_got = csrFb.rdata;
                csr.read = 1'b0;
            end
        end
`ifdef OC_LIBRARY_CSR_ADAPTER_TIMEOUT_EN
        chk("timeout strobes", strobes, 8);
        chk("timeout latency", lat, 9);
        chk("timeout error", err_got, 1);
        chk("timeout rdata", rd_got, 0);
`else
        chk("no-timeout strobes", strobes, 130);
        chk("no-timeout latency", lat, -1);
        @(negedge clock);
        csr.read = 1'b0;
        localReady = 1'b1;
        localRdata = 32'h0;
        @(posedge clock);
        #1;
        localReady = 1'b0;
        chk("no-timeout late ready", csrFb.ready, 1);
        repeat (2) @(negedge clock);
`endif

        // Reset while in Access, request still held afterwards.
        @(negedge clock);
        csr = '{toblock: 32'h12, space: 4'h1, address: 32'h90, wdata: 32'h0, read: 1'b1, write: 1'b0};
        localReady = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("pre-reset strobe", localRead, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid reset strobe", {localRead, localWrite}, 0);
        chk("mid reset addr", localAddress, 0);
        chk("mid reset fb", csrFb, 0);
        @(negedge clock);
        reset = 1'b0;
        readies = 0;
        strobes = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock);
            #1;
            if (csrFb.ready) begin
                readies++;
                csr.read = 1'b0;
            end
            if (localRead) begin
                strobes++;
                localReady = 1'b1;
                localRdata = 32'hBEEF0090;
            end else localReady = 1'b0;
        end
        chk("post reset re-accept strobes", strobes, 1);
        chk("post reset ready count", readies, 1);
        chk("post reset addr", localAddress, 32'h90);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oclib_csr_local_adapter.md
# oclib_csr_local_adapter

Terminates a CSR request on a block's local register port. It sits directly downstream of `oclib_csr_check_selected`, which it instantiates to decide whether a request on the CSR tree/NOC belongs to this block. Accepted read and write requests become a held local access, and the block returns exactly one feedback response per request. Requests for other blocks get an all-zero feedback, so feedback from many blocks can be OR-combined.

## Interface
Parameters:
- `CsrType`, default `oclib_pkg::csr_32_noc_s`: request struct. Fields: `toblock[31:0]` (leftmost), `space[3:0]`, `address[31:0]`, `wdata[31:0]`, `read`, `write`.
- `CsrFbType`, default `oclib_pkg::csr_32_noc_fb_s`: feedback struct. Fields: `rdata[31:0]`, `ready`, `error`.
- `AnswerToBlock`, default `oclib_pkg::BcBlockIdAny`: block ID this instance accepts.
- `AnswerToSpace`, default `oclib_pkg::BcSpaceIdAny`: space ID this instance accepts.
- `TimeoutCycles`, default 1024: local-access timeout. Range 2..65535.

Ports:
- `clock`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `csrSelect`, in, 1: qualifies the request. Tie to 1 when the block is unconditionally on the tree.
- `csr`, in, `CsrType`: request.
- `csrFb`, out, `CsrFbType`: feedback.
- `localRead`, out, 1: local read, held until done.
- `localWrite`, out, 1: local write, held until done.
- `localAddress`, out, 32: captured `csr.address`.
- `localWdata`, out, 32: captured `csr.wdata`.
- `localRdata`, in, 32: read data, valid while `localReady`.
- `localReady`, in, 1: completion. Sampled only while `localRead` or `localWrite` is high.
- `localError`, in, 1: error qualifier, valid with `localReady`.

## Operation
- A request is level-signalled: `csr.read` or `csr.write` is held by the requester until `csrFb.ready` is seen.
- `match` comes combinationally from the `oclib_csr_check_selected` instance (`csrSelect`, `csr`, block and space parameters).
- The FSM has four states: Idle, Access, Respond, Release.
- Idle:
  - `match && (read ^ write)`: latch address and wdata, assert `localRead` or `localWrite`, go to Access.
  - `match && read && write`: go to Respond with error=1 and rdata=0. No local access is made.
  - Otherwise remain in Idle.
- Access:
  - Hold the local strobes, address and wdata stable.
  - On `localReady`: capture rdata (reads only; writes return 0) and `localError`, drop the strobes, go to Respond.
- Respond:
  - Drive `csrFb.ready`=1 for exactly one cycle with the captured rdata and error.
  - Go to Release.
- Release:
  - Wait until `csr.read`=0 and `csr.write`=0, then go to Idle.
  - This stops a still-held request from being re-accepted.
- `csrFb` is all-zero in every state except Respond. Non-matching requests never change state.
- Changes to `csr` during Access or Release are ignored; the fields were captured at acceptance.

## Timing
- Reset values: all outputs 0, state Idle, timeout counter 0.
- Read/write path:
  - Request valid at edge 0 → strobe high after edge 1.
  - `localReady` high in the cycle ending at edge N → strobe low and `csrFb.ready` high after edge N.
  - `csrFb.ready` low after edge N+1.
- Minimum latency, request to `ready`: 2 cycles (`localReady` tied high).
- Read+write collision: `ready` with error high after edge 1.
- Back-to-back requests: at least one idle cycle of deasserted request between accepts, enforced by Release.
- A `localReady` arriving the same cycle the timeout expires is accepted as success.
- Reset in mid-operation: all outputs drop asynchronously and no response is issued. A request still held after reset releases is re-accepted from Idle.

## Configuration
- Macro `OC_LIBRARY_CSR_ADAPTER_TIMEOUT_EN`.
- When defined:
  - A 16-bit counter clears on entry to Access and increments each Access cycle.
  - When it reaches `TimeoutCycles-1` with no `localReady`: drop the strobes and go to Respond with error=1, rdata=0.
- When undefined:
  - No counter is built.
  - Access waits indefinitely for `localReady`.

## Structure
- `CsrFbType` typedef `csr_32_noc_fb_s` and the FSM state enum belong in `oclib_pkg`, beside the existing CSR structs and `BcBlockIdAny`/`BcSpaceIdAny`.
- Sub-module: one `oclib_csr_check_selected` instance, with parameters passed straight through. No other hierarchy.

## Test plan
- Read, matched block 0x12, space 1, address 0x40; `localReady` 3 cycles later with rdata 0xDEADBEEF → `localRead` held 3 cycles, address 0x40, one-cycle `ready` with rdata 0xDEADBEEF, error 0.
- Write wdata 0xA5A5A5A5 to a non-matching block 0x13 → no strobes, `csrFb` stays 0. Same write to 0x12 → `localWrite` asserted, `localWdata`=0xA5A5A5A5, `ready` with rdata 0.
- read=write=1 to a matched block → no strobes, `ready`+error after edge 1. Request held 10 cycles → only one `ready`.
- Macro defined, `TimeoutCycles`=8, `localReady` never asserted → strobe high 8 cycles, then `ready`+error. Macro undefined → strobe stays high 100+ cycles with no `ready`.
- `reset` pulsed in Access → outputs 0 immediately. Request still held → re-accepted after reset; exactly one `ready` observed after reset.
- `localReady`+`localError` on a write → `ready` with error 1.
